weight_dbuf_ctrl: RTL and testbench

//   Ping-pong weight buffer feeding the mux2_32b operand-select stage of the TPU datapath.

---
 rtl/weight_dbuf_ctrl.sv | 120 ++++++++++++
 tb/tb_weight_dbuf_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/weight_dbuf_ctrl.sv
// Ping-pong weight buffer: fills the shadow bank from the loader and swaps banks on tile
// boundaries, driving mux_sel so the downstream 2:1 operand mux passes the active bank.
module weight_dbuf_ctrl #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              swap_req,
  output logic              swap_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  bank_a_q,
  output logic [WIDTH-1:0]  bank_b_q,
  output logic              mux_sel,
  output logic              act_valid
);

  typedef enum logic [1:0] {
    PRIME = 2'd0,  // active bank not yet valid
    FILL  = 2'd1,  // active bank valid, shadow filling
    READY = 2'd2   // shadow full, waiting for a swap
  } state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  bank_a [DEPTH];
  logic [WIDTH-1:0]  bank_b [DEPTH];
  logic [ADDR_W-1:0] wr_cnt;
  logic              pending, pending_nxt;
  logic              mux_sel_nxt, act_valid_nxt, swap_ack_nxt;
  logic              wr_fire, wr_last;

  // Ready depends on state alone so the loader never sees a valid->ready loop.
  assign wr_ready = (state != READY);
  assign wr_fire  = wr_valid && wr_ready;
  assign wr_last  = wr_fire && (wr_cnt == ADDR_W'(DEPTH - 1));

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    pending_nxt   = pending;
    mux_sel_nxt   = mux_sel;
    act_valid_nxt = act_valid;
    swap_ack_nxt  = 1'b0;
    unique case (state)
      PRIME: begin
        pending_nxt = pending | swap_req;
        if (wr_last) begin
          // First tile completes: swap without waiting for the consumer.
          mux_sel_nxt   = ~mux_sel;
          act_valid_nxt = 1'b1;
          swap_ack_nxt  = 1'b1;
          pending_nxt   = 1'b0;
          state_nxt     = FILL;
        end
      end
      FILL: begin
        pending_nxt = pending | swap_req;
        if (wr_last) state_nxt = READY;
      end
      READY: begin
        if (swap_req || pending) begin
          mux_sel_nxt  = ~mux_sel;
          swap_ack_nxt = 1'b1;
          pending_nxt  = 1'b0;
          state_nxt    = FILL;
        end
      end
      default: state_nxt = PRIME;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PRIME;
      pending   <= 1'b0;
      mux_sel   <= 1'b0;
      act_valid <= 1'b0;
      swap_ack  <= 1'b0;
      wr_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      mux_sel   <= mux_sel_nxt;
      act_valid <= act_valid_nxt;
      swap_ack  <= swap_ack_nxt;
      if (wr_fire) wr_cnt <= wr_cnt + 1'b1;  // DEPTH is a power of two, so this wraps
    end
  end

  // NOTE: the banks are reset explicitly because a reset buffer must read back zeros;
  // this keeps them in flops rather than a RAM macro, which is fine at this depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_a[i] <= '0;
        bank_b[i] <= '0;
      end
    end else if (wr_fire) begin
      if (!mux_sel) bank_a[wr_cnt] <= wr_data;
      else          bank_b[wr_cnt] <= wr_data;
    end
  end

  // Registered read of both banks; a same-cycle write returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_a_q <= '0;
      bank_b_q <= '0;
    end else begin
      bank_a_q <= bank_a[rd_addr];
      bank_b_q <= bank_b[rd_addr];
    end
  end

endmodule

// File: tb/tb_weight_dbuf_ctrl.sv
// Testbench for weight_dbuf_ctrl: directed tile scenarios plus randomized traffic checked
// against a tile-level model (word counts per bank, active-bank index, outstanding request).
module tb_weight_dbuf_ctrl;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [WIDTH-1:0]  wr_data = '0;
  logic              swap_req = 1'b0;
  logic              swap_ack;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [WIDTH-1:0]  bank_a_q, bank_b_q;
  logic              mux_sel, act_valid;

  int total = 0;
  int bad   = 0;

  weight_dbuf_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .swap_req(swap_req), .swap_ack(swap_ack),
    .rd_addr(rd_addr), .bank_a_q(bank_a_q), .bank_b_q(bank_b_q),
    .mux_sel(mux_sel), .act_valid(act_valid)
  );

  always #5 clk = ~clk;

  // Reference model. Bank index 0 = A, 1 = B; the active bank is A when m_sel is 1.
  logic [WIDTH-1:0] m_mem [2][DEPTH];
  bit               m_sel, m_valid, m_want, m_ack;
  int               m_cnt;   // words already placed in the shadow bank (0..DEPTH)
  logic [WIDTH-1:0] m_qa, m_qb;

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < DEPTH; i++) m_mem[b][i] = '0;
    m_sel = 0; m_valid = 0; m_want = 0; m_ack = 0; m_cnt = 0;
    m_qa = '0; m_qb = '0;
  endtask

  task automatic model_step(input bit v, input logic [WIDTH-1:0] d, input bit s,
                            input int a);
    bit full_before;
    int shadow;
    full_before = (m_cnt == DEPTH);
    shadow      = m_sel ? 1 : 0;
    m_qa  = m_mem[0][a];
    m_qb  = m_mem[1][a];
    m_ack = 0;
    if (v && m_cnt < DEPTH) begin
      m_mem[shadow][m_cnt] = d;
      m_cnt++;
    end
    if (!m_valid) begin
      m_want = 0;  // a request before the first tile is covered by the automatic swap
      if (m_cnt == DEPTH) begin
        m_sel = !m_sel; m_valid = 1; m_ack = 1; m_cnt = 0;
      end
    end else if (full_before && (s || m_want)) begin
      m_sel = !m_sel; m_ack = 1; m_cnt = 0; m_want = 0;
    end else if (s) begin
      m_want = 1;
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, settle just after it.
  task automatic tick(input bit v, input logic [WIDTH-1:0] d, input bit s, input int a);
    wr_valid = v; wr_data = d; swap_req = s; rd_addr = ADDR_W'(a);
    @(posedge clk);
    model_step(v, d, s, a);
    #1;
    wr_valid = 1'b0; swap_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (mux_sel !== 1'b0)   begin bad++; $display("FAIL reset_mux_sel got=%b exp=0", mux_sel); end
    total++; if (act_valid !== 1'b0) begin bad++; $display("FAIL reset_act_valid got=%b exp=0", act_valid); end
    total++; if (swap_ack !== 1'b0)  begin bad++; $display("FAIL reset_swap_ack got=%b exp=0", swap_ack); end
    total++; if (bank_a_q !== '0 || bank_b_q !== '0)
      begin bad++; $display("FAIL reset_q got a=%h b=%h exp=0", bank_a_q, bank_b_q); end
    rst_n = 1'b1;
    #1;
    total++; if (wr_ready !== 1'b1)  begin bad++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
  endtask

  task automatic test_prime();
    logic [WIDTH-1:0] words [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) begin
      tick(1, words[i], 0, 0);
      if (i < 3) begin
        total++; if (swap_ack !== 1'b0) begin bad++; $display("FAIL prime_early_ack word=%0d got=%b exp=0", i, swap_ack); end
      end
    end
    total++; if (swap_ack !== 1'b1)  begin bad++; $display("FAIL prime_ack got=%b exp=1", swap_ack); end
    total++; if (mux_sel !== 1'b1)   begin bad++; $display("FAIL prime_mux_sel got=%b exp=1", mux_sel); end
    total++; if (act_valid !== 1'b1) begin bad++; $display("FAIL prime_act_valid got=%b exp=1", act_valid); end
    tick(0, '0, 0, 2);
    total++; if (swap_ack !== 1'b0)  begin bad++; $display("FAIL prime_ack_pulse got=%b exp=0", swap_ack); end
    total++; if (bank_a_q !== 32'h33) begin bad++; $display("FAIL prime_read_a2 got=%h exp=33", bank_a_q); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) tick(1, 32'hA0 + WIDTH'(i), 0, 0);
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL bp_wr_ready got=%b exp=0", wr_ready); end
    tick(1, 32'hFF, 0, 0);
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL bp_wr_ready_held got=%b exp=0", wr_ready); end
    total++; if (mux_sel !== 1'b1 || swap_ack !== 1'b0)
      begin bad++; $display("FAIL bp_no_swap got mux_sel=%b ack=%b exp 1/0", mux_sel, swap_ack); end
    tick(0, '0, 0, 0);
    total++; if (bank_b_q !== 32'hA0) begin bad++; $display("FAIL bp_b0_kept got=%h exp=a0", bank_b_q); end
  endtask

  task automatic test_early_request();
    tick(0, '0, 1, 0);   // release the full B tile: B becomes active
    total++; if (swap_ack !== 1'b1 || mux_sel !== 1'b0)
      begin bad++; $display("FAIL early_release got ack=%b mux_sel=%b exp 1/0", swap_ack, mux_sel); end
    tick(1, 32'h51, 0, 0);
    tick(0, '0, 1, 0);   // request after one word
    for (int i = 1; i < 4; i++) tick(1, 32'h51 + WIDTH'(i), 0, 0);
    total++; if (swap_ack !== 1'b0 || mux_sel !== 1'b0)
      begin bad++; $display("FAIL early_at_last got ack=%b mux_sel=%b exp 0/0", swap_ack, mux_sel); end
    tick(0, '0, 0, 0);
    total++; if (swap_ack !== 1'b1 || mux_sel !== 1'b1)
      begin bad++; $display("FAIL early_swap got ack=%b mux_sel=%b exp 1/1", swap_ack, mux_sel); end
    tick(0, '0, 0, 0);
    total++; if (swap_ack !== 1'b0 || mux_sel !== 1'b1 || wr_ready !== 1'b1)
      begin bad++; $display("FAIL early_pending_cleared got ack=%b mux_sel=%b rdy=%b exp 0/1/1", swap_ack, mux_sel, wr_ready); end
  endtask

  task automatic test_collision();
    for (int i = 0; i < 3; i++) tick(1, 32'h61 + WIDTH'(i), 0, 0);
    tick(1, 32'h64, 1, 0);
    total++; if (swap_ack !== 1'b0 || mux_sel !== 1'b1)
      begin bad++; $display("FAIL coll_same_cycle got ack=%b mux_sel=%b exp 0/1", swap_ack, mux_sel); end
    tick(0, '0, 0, 0);
    total++; if (swap_ack !== 1'b1 || mux_sel !== 1'b0)
      begin bad++; $display("FAIL coll_swap got ack=%b mux_sel=%b exp 1/0", swap_ack, mux_sel); end
    tick(0, '0, 0, 0);
    total++; if (swap_ack !== 1'b0 || mux_sel !== 1'b0)
      begin bad++; $display("FAIL coll_single_toggle got ack=%b mux_sel=%b exp 0/0", swap_ack, mux_sel); end
    for (int i = 0; i < 4; i++) begin
      tick(0, '0, 0, i);
      total++; if (bank_b_q !== 32'h61 + WIDTH'(i))
        begin bad++; $display("FAIL coll_read addr=%0d got=%h exp=%h", i, bank_b_q, 32'h61 + i); end
    end
  endtask

  task automatic test_reset_midfill();
    tick(1, 32'hE1, 0, 0);
    tick(1, 32'hE2, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #2;
    total++; if (act_valid !== 1'b0 || mux_sel !== 1'b0 || swap_ack !== 1'b0)
      begin bad++; $display("FAIL midrst_ctrl got valid=%b mux_sel=%b ack=%b exp 0/0/0", act_valid, mux_sel, swap_ack); end
    total++; if (bank_b_q !== '0 || wr_ready !== 1'b1)
      begin bad++; $display("FAIL midrst_out got b_q=%h rdy=%b exp 0/1", bank_b_q, wr_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(0, '0, 0, 1);
    total++; if (bank_a_q !== '0) begin bad++; $display("FAIL midrst_discard got=%h exp=0", bank_a_q); end
    for (int i = 0; i < 4; i++) tick(1, 32'h71 + WIDTH'(i), 0, 0);
    total++; if (swap_ack !== 1'b1 || mux_sel !== 1'b1 || act_valid !== 1'b1)
      begin bad++; $display("FAIL midrst_refill got ack=%b mux_sel=%b valid=%b exp 1/1/1", swap_ack, mux_sel, act_valid); end
    tick(0, '0, 0, 0);
    total++; if (bank_a_q !== 32'h71) begin bad++; $display("FAIL midrst_read got=%h exp=71", bank_a_q); end
  endtask

  task automatic test_random();
    bit v, s;
    int a;
    logic [WIDTH-1:0] d;
    for (int c = 0; c < 600; c++) begin
      v = ($urandom_range(3) != 0);
      s = ($urandom_range(7) == 0);
      a = int'($urandom_range(DEPTH - 1));
      d = $urandom;
      tick(v, d, s, a);
      total++;
      if (mux_sel !== m_sel || act_valid !== m_valid || swap_ack !== m_ack ||
          wr_ready !== (m_cnt < DEPTH) || bank_a_q !== m_qa || bank_b_q !== m_qb) begin
        bad++;
        $display("FAIL rand cyc=%0d got sel=%b val=%b ack=%b rdy=%b a=%h b=%h exp sel=%b val=%b ack=%b rdy=%b a=%h b=%h",
                 c, mux_sel, act_valid, swap_ack, wr_ready, bank_a_q, bank_b_q,
                 m_sel, m_valid, m_ack, (m_cnt < DEPTH), m_qa, m_qb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_prime();
    test_backpressure();
    test_early_request();
    test_collision();
    test_reset_midfill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
